// File: rtl/truth_table_sequencer_pkg.sv
// Shared types and constants for the truth-table sequencer.
// State encoding is 2 bits; default expectation is the NAND table.
package truth_table_sequencer_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRIVE  = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam int         NUM_VECTORS    = 4;
  localparam int         ERR_W          = 3;
  localparam logic [3:0] DEFAULT_EXPECT = 4'b0111;

endpackage

// File: rtl/truth_table_sequencer_if.sv
// Bus between the sequencer and whoever hosts the gate under test.
// master drives start/s_in; slave is the sequencer itself.
interface truth_table_sequencer_if;
  import truth_table_sequencer_pkg::*;

  logic             start;
  logic             s_in;
  logic             a;
  logic             b;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic [3:0]       fail_mask;

  modport master (
    output start,
    output s_in,
    input  a,
    input  b,
    input  busy,
    input  done,
    input  pass,
    input  err_count,
    input  fail_mask
  );

  modport slave (
    input  start,
    input  s_in,
    output a,
    output b,
    output busy,
    output done,
    output pass,
    output err_count,
    output fail_mask
  );

endinterface

// File: rtl/truth_table_sequencer.sv
// Sweeps a 2-input gate through 00,01,10,11 (two cycles per vector)
// and records which vectors disagree with the EXPECT table.
module truth_table_sequencer
  import truth_table_sequencer_pkg::*;
#(
  parameter logic [3:0] EXPECT = DEFAULT_EXPECT
) (
  input logic                     clk,
  input logic                     rst,
  truth_table_sequencer_if.slave  bus
);

  state_t           r_state;
  state_t           w_state_nx;
  logic [1:0]       r_idx;
  logic [1:0]       w_idx_nx;
  logic [ERR_W-1:0] r_err;
  logic [ERR_W-1:0] w_err_nx;
  logic [3:0]       r_mask;
  logic [3:0]       w_mask_nx;
  logic             w_miss;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= 2'd0;
      r_err   <= '0;
      r_mask  <= 4'd0;
    end else begin
      r_state <= w_state_nx;
      r_idx   <= w_idx_nx;
      r_err   <= w_err_nx;
      r_mask  <= w_mask_nx;
    end
  end

  assign w_miss = (bus.s_in != EXPECT[r_idx]);

  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    w_err_nx   = r_err;
    w_mask_nx  = r_mask;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          w_state_nx = S_DRIVE;
          w_idx_nx   = 2'd0;
          w_err_nx   = '0;
          w_mask_nx  = 4'd0;
        end
      end
      S_DRIVE: begin
        w_state_nx = S_SAMPLE;
      end
      S_SAMPLE: begin
        if (w_miss) begin
          w_mask_nx[r_idx] = 1'b1;
          // Saturate: at most one miss per vector anyway.
          if (r_err < ERR_W'(NUM_VECTORS))
            w_err_nx = r_err + ERR_W'(1);
        end
        if (r_idx == 2'd3) begin
          w_state_nx = S_DONE;
        end else begin
          w_state_nx = S_DRIVE;
          w_idx_nx   = r_idx + 2'd1;
        end
      end
    endcase
  end

  // a/b come straight from the index register, so they are glitch-free.
  assign bus.a         = r_idx[1];
  assign bus.b         = r_idx[0];
  assign bus.busy      = (r_state == S_DRIVE) ||
                         (r_state == S_SAMPLE);
  assign bus.done      = (r_state == S_DONE);
  assign bus.pass      = (r_state == S_DONE) &&
                         (r_err == '0);
  assign bus.err_count = r_err;
  assign bus.fail_mask = r_mask;

endmodule

// File: doc/truth_table_sequencer.md
TRUTH_TABLE_SEQUENCER -- requirements
Module: truth_table_sequencer

Interface
REQ-001 Parameter EXPECT, 4 bits, default 4'b0111: expected gate output for each input vector, indexed by {a,b}; the default is the NAND truth table.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to run one full truth-table sweep.
REQ-005 s_in  input  1  output of the 2-input gate under test, driven by a/b below.
REQ-006 a  output  1  first gate input, registered.
REQ-007 b  output  1  second gate input, registered.
REQ-008 busy  output  1  sweep in progress (DRIVE or SAMPLE state).
REQ-009 done  output  1  sweep complete; held in DONE state.
REQ-010 pass  output  1  done with zero mismatches.
REQ-011 err_count  output  3  number of mismatching vectors, range 0..4.
REQ-012 fail_mask  output  4  bit {a,b} set when that vector mismatched.

Function
REQ-013 FSM states SHALL be IDLE, DRIVE, SAMPLE, DONE.
REQ-014 IDLE: on an edge with start=1 -> DRIVE; clear idx, err_count and fail_mask; set {a,b}=2'b00.
REQ-015 DRIVE: unconditionally -> SAMPLE on the next edge; a/b held (one full settle cycle for the gate under test).
REQ-016 SAMPLE: on the edge leaving SAMPLE, compare s_in with EXPECT[idx]; on mismatch set fail_mask[idx] and increment err_count.
REQ-017 SAMPLE with idx<3 -> DRIVE; idx increments and {a,b} updates to the new idx on the same edge.
REQ-018 SAMPLE with idx==3 -> DONE; a/b hold 2'b11.
REQ-019 Vector order SHALL be 00, 01, 10, 11, with a as the MSB of idx.
REQ-020 Each vector SHALL occupy exactly 2 cycles; done SHALL rise on the 8th rising edge after the edge that accepted start.
REQ-021 busy SHALL be 1 exactly in DRIVE and SAMPLE.
REQ-022 done SHALL be 1 exactly in DONE; pass = done AND (err_count==0); pass SHALL be 0 outside DONE.
REQ-023 err_count and fail_mask SHALL remain stable in DONE until the next accepted start or rst.
REQ-024 start SHALL be ignored in DRIVE and SAMPLE; no restart and no counter change.
REQ-025 DONE: on an edge with start=1 -> DRIVE, with the same clearing as REQ-014; otherwise remain in DONE.
REQ-026 err_count SHALL never exceed 4 and SHALL NOT wrap.
REQ-027 s_in SHALL be sampled only on the edge leaving SAMPLE; s_in values in IDLE, DRIVE or DONE SHALL have no effect.

Reset
REQ-028 When rst=1 at an edge, the block SHALL enter IDLE with a=0, b=0, idx=0, busy=0, done=0, pass=0, err_count=0, fail_mask=0.
REQ-029 rst SHALL take priority over start and over any in-progress sweep, including mid-vector; partial results SHALL be discarded.
REQ-030 With rst=1 and start=1 on the same edge, the block SHALL stay in IDLE; start SHALL be accepted only on a later edge with rst=0.

Structure
REQ-031 A shared package SHALL hold the state encoding (2-bit), NUM_VECTORS=4 and DEFAULT_EXPECT=4'b0111.
REQ-032 The block SHALL be a single module with no sub-modules.
REQ-033 The gate under test SHALL be instantiated outside the block, in the bench or top level, and connected via a, b and s_in.

Verification
REQ-034 NOR-built NAND connected, start pulsed 1 cycle -> a/b = 00,01,10,11 for 2 cycles each; done after 8 edges; err_count=0, fail_mask=0000, pass=1.
REQ-035 s_in tied to 0 -> err_count=3, fail_mask=4'b0111, pass=0, done=1.
REQ-036 s_in = a AND b (inverted gate) -> err_count=4, fail_mask=4'b1111, pass=0.
REQ-037 rst asserted at the SAMPLE of vector 10 -> next edge all outputs 0 and IDLE; a later start completes a clean sweep matching REQ-034.
REQ-038 start held high throughout -> busy stays 1 for the 8 sweep cycles with no restart; DONE is visible for 1 cycle, then a new sweep starts with counters cleared.
REQ-039 EXPECT=4'b1000 (AND) with an AND gate under test -> pass=1; same bench with the NAND gate -> err_count=4.
